// File: rtl/tc_pkg.sv
// Shared constants and ID pack/unpack helpers for the
// tensor-core scheduler and the core it feeds.
package tc_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int D_MODEL_DEF   = 64;
  localparam int ID_WIDTH_DEF  = 20;
  localparam int TAG_W_DEF     = 8;
  localparam int CPL_DEPTH_DEF = 16;

  function automatic logic [31:0] lo_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] id_pack(
    input logic [31:0] req,
    input logic [31:0] tag,
    input int          tag_w,
    input int          id_w
  );
    return ((req << tag_w) | (tag & lo_mask(tag_w)))
           & lo_mask(id_w);
  endfunction

  function automatic logic [31:0] id_req(
    input logic [31:0] id,
    input int          tag_w,
    input int          req_w
  );
    return (id >> tag_w) & lo_mask(req_w);
  endfunction

  function automatic logic [31:0] id_tag(
    input logic [31:0] id,
    input int          tag_w
  );
    return id & lo_mask(tag_w);
  endfunction

endpackage

// File: rtl/tc_cpl_fifo.sv
// Completion FIFO: synchronous, head word read straight
// from the storage flops, no write-to-read bypass.
module tc_cpl_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  // storage, cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wptr] <= wr_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr)
        wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (do_rd)
        rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tc_scheduler.sv
// Round-robin issue of vector pairs into one tensor core,
// with credit-protected in-order completion return.
module tc_scheduler
  import tc_pkg::*;
#(
  parameter  int N_REQ     = N_REQ_DEF,
  parameter  int D_MODEL   = D_MODEL_DEF,
  parameter  int ID_WIDTH  = ID_WIDTH_DEF,
  parameter  int TAG_W     = TAG_W_DEF,
  parameter  int CPL_DEPTH = CPL_DEPTH_DEF,
  localparam int REQ_W     = $clog2(N_REQ),
  localparam int CW        = $clog2(CPL_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic [N_REQ-1:0]                     req_valid,
  output logic [N_REQ-1:0]                     req_ready,
  input  logic [N_REQ-1:0][D_MODEL-1:0][7:0]   req_vec_a,
  input  logic [N_REQ-1:0][D_MODEL-1:0][7:0]   req_vec_b,
  input  logic [N_REQ-1:0][TAG_W-1:0]          req_tag,
  output logic                                 tc_valid_in,
  output logic [D_MODEL-1:0][7:0]              tc_vec_a,
  output logic [D_MODEL-1:0][7:0]              tc_vec_b,
  output logic [ID_WIDTH-1:0]                  tc_vec_id,
  input  logic                                 tc_valid_out,
  input  logic signed [31:0]                   tc_dot_product,
  input  logic [ID_WIDTH-1:0]                  tc_id_out,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic signed [31:0]                   rsp_data,
  output logic [REQ_W-1:0]                     rsp_req,
  output logic [TAG_W-1:0]                     rsp_tag,
  output logic [CW-1:0]                        credit_cnt,
  output logic                                 busy,
  output logic                                 err
);

  localparam int            FW   = 32 + REQ_W + TAG_W;
  localparam logic [CW-1:0] FULL = CW'(CPL_DEPTH);

  logic [REQ_W-1:0] last;
  logic [REQ_W-1:0] sel;
  logic [REQ_W-1:0] idx;
  logic             found;
  logic             hs;
  logic             pop;
  logic [CW-1:0]    inflight;
  logic [31:0]      id_full;
  logic [31:0]      rx_req;
  logic [31:0]      rx_tag;
  logic [FW-1:0]    wr_data;
  logic [FW-1:0]    rd_data;
  logic             f_full;
  logic             f_empty;
  logic [CW-1:0]    f_count;
  logic             spur;
  logic             drop;
  logic             unused_ok;

  // round-robin pick, starting just after the last grant
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = REQ_W'(int'(last) + k);
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign hs  = found && (credit_cnt != '0);
  assign pop = rsp_valid && rsp_ready;

  // one-hot grant, gated by credit availability only
  always_comb begin
    req_ready = '0;
    if (hs) req_ready[sel] = 1'b1;
  end

  assign id_full = id_pack(32'(sel), 32'(req_tag[sel]),
                           TAG_W, ID_WIDTH);

  // round-robin pointer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) last <= REQ_W'(N_REQ - 1);
    else if (hs) last <= sel;
  end

  // issue register toward the core
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tc_valid_in <= 1'b0;
      tc_vec_a    <= '0;
      tc_vec_b    <= '0;
      tc_vec_id   <= '0;
    end else begin
      tc_valid_in <= hs;
      if (hs) begin
        tc_vec_a  <= req_vec_a[sel];
        tc_vec_b  <= req_vec_b[sel];
        tc_vec_id <= id_full[ID_WIDTH-1:0];
      end
    end
  end

  // credits: one per free completion slot
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      credit_cnt <= FULL;
    else if (hs && !pop)
      credit_cnt <= credit_cnt - CW'(1);
    else if (pop && !hs && credit_cnt != FULL)
      credit_cnt <= credit_cnt + CW'(1);
  end

  assign busy = (credit_cnt != FULL);

  // results issued to the core but not yet returned
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight <= '0;
    end else begin
      unique case ({tc_valid_in, tc_valid_out && inflight != '0})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign spur = tc_valid_out && (inflight == '0);
  assign drop = tc_valid_out && f_full && !pop;

  // sticky protocol error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err <= 1'b0;
    else if (spur || drop) err <= 1'b1;
  end

  assign rx_req  = id_req(32'(tc_id_out), TAG_W, REQ_W);
  assign rx_tag  = id_tag(32'(tc_id_out), TAG_W);
  assign wr_data = {tc_dot_product,
                    rx_req[REQ_W-1:0],
                    rx_tag[TAG_W-1:0]};

  tc_cpl_fifo #(
    .W     (FW),
    .DEPTH (CPL_DEPTH)
  ) u_cpl (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (tc_valid_out),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  assign rsp_valid = !f_empty;
  assign rsp_data  = rd_data[FW-1 -: 32];
  assign rsp_req   = rd_data[TAG_W +: REQ_W];
  assign rsp_tag   = rd_data[TAG_W-1:0];

  assign unused_ok = ^{f_count, rx_req, rx_tag};

endmodule

// File: tb/tb_tc_scheduler.sv
// Self-checking bench for tc_scheduler: behavioural core,
// round-robin/credit reference model and result scoreboard.
module tb_tc_scheduler;

  localparam int N     = 4;
  localparam int D     = 64;
  localparam int L     = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int data;
    int req;
    int tag;
  } exp_t;

  logic                     clk;
  logic                     nrst;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0][D-1:0][7:0] req_vec_a;
  logic [N-1:0][D-1:0][7:0] req_vec_b;
  logic [N-1:0][7:0]        req_tag;
  logic                     tc_valid_in;
  logic [D-1:0][7:0]        tc_vec_a;
  logic [D-1:0][7:0]        tc_vec_b;
  logic [19:0]              tc_vec_id;
  logic                     tc_valid_out;
  logic signed [31:0]       tc_dot_product;
  logic [19:0]              tc_id_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic signed [31:0]       rsp_data;
  logic [1:0]               rsp_req;
  logic [7:0]               rsp_tag;
  logic [4:0]               credit_cnt;
  logic                     busy;
  logic                     err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_m;
  int   cred_m;
  int   dut_hs = 0;
  int   base;
  bit   prev_hs;
  logic [19:0] prev_id;
  int   pop_data;
  int   pop_req;
  int   pop_tag;
  exp_t q[$];

  bit                v[N];
  bit                rr;
  bit                inj;
  logic [D-1:0][7:0] pa[N];
  logic [D-1:0][7:0] pb[N];
  logic [7:0]        pt[N];

  bit          pv[L];
  int          pd[L];
  logic [19:0] pid[L];

  tc_scheduler dut (
    .clk            (clk),
    .nrst           (nrst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vec_a      (req_vec_a),
    .req_vec_b      (req_vec_b),
    .req_tag        (req_tag),
    .tc_valid_in    (tc_valid_in),
    .tc_vec_a       (tc_vec_a),
    .tc_vec_b       (tc_vec_b),
    .tc_vec_id      (tc_vec_id),
    .tc_valid_out   (tc_valid_out),
    .tc_dot_product (tc_dot_product),
    .tc_id_out      (tc_id_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_req        (rsp_req),
    .rsp_tag        (rsp_tag),
    .credit_cnt     (credit_cnt),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dot(input logic [D-1:0][7:0] a,
                             input logic [D-1:0][7:0] b);
    int s;
    s = 0;
    for (int i = 0; i < D; i++)
      s += int'($signed(a[i])) * int'($signed(b[i]));
    return s;
  endfunction

  // in-order core model with fixed latency and injectable strobe
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < L; i++) begin
        pv[i]  = 1'b0;
        pd[i]  = 0;
        pid[i] = '0;
      end
      tc_valid_out   = 1'b0;
      tc_dot_product = 0;
      tc_id_out      = '0;
    end else begin
      #1;
      for (int i = L - 1; i > 0; i--) begin
        pv[i]  = pv[i-1];
        pd[i]  = pd[i-1];
        pid[i] = pid[i-1];
      end
      pv[0]          = tc_valid_in;
      pd[0]          = dot(tc_vec_a, tc_vec_b);
      pid[0]         = tc_vec_id;
      tc_valid_out   = pv[L-1] | inj;
      tc_dot_product = pd[L-1];
      tc_id_out      = pid[L-1];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic newpay(input int i);
    for (int e = 0; e < D; e++) begin
      pa[i][e] = 8'($urandom);
      pb[i][e] = 8'($urandom);
    end
    pt[i] = 8'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_vec_a[i] = pa[i];
      req_vec_b[i] = pb[i];
      req_tag[i]   = pt[i];
    end
    rsp_ready = rr;
  endtask

  task automatic model_reset();
    q.delete();
    last_m  = N - 1;
    cred_m  = DEPTH;
    prev_hs = 1'b0;
    prev_id = '0;
  endtask

  // one cycle; mode after a grant: 0 drop, 1 hold, 2 random
  task automatic step(input int mode);
    int   g;
    logic [3:0] exp_rdy;
    exp_t e;
    drive();
    #1;
    chk("tc_valid_in", tc_valid_in, prev_hs);
    if (prev_hs) chk("tc_vec_id", tc_vec_id, prev_id);
    chk("credit_cnt", credit_cnt, cred_m);
    chk("busy", busy, cred_m != DEPTH);
    g = -1;
    if (cred_m > 0)
      for (int k = 1; k <= N; k++)
        if (g < 0 && v[(last_m + k) % N]) g = (last_m + k) % N;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", req_ready, exp_rdy);
    if (req_ready != 0) dut_hs++;
    if (rsp_valid && rr) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_req", rsp_req, e.req);
        chk("rsp_tag", rsp_tag, e.tag);
        pop_data = rsp_data;
        pop_req  = rsp_req;
        pop_tag  = rsp_tag;
      end
      if (cred_m < DEPTH) cred_m++;
    end
    if (g >= 0) begin
      e.data = dot(pa[g], pb[g]);
      e.req  = g;
      e.tag  = pt[g];
      q.push_back(e);
      prev_hs = 1'b1;
      prev_id = 20'(g * 256 + pt[g]);
      last_m  = g;
      cred_m--;
      newpay(g);
      if (mode == 0) v[g] = 1'b0;
      else if (mode == 2) v[g] = 1'($urandom_range(0, 1));
    end else begin
      prev_hs = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    rr = 1'b1;
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    for (int i = 0; i < 100 && (q.size() != 0 || cred_m != DEPTH); i++)
      step(0);
    chk("drain_queue", q.size(), 0);
    chk("drain_credit", credit_cnt, DEPTH);
  endtask

  initial begin
    nrst = 1'b1;
    inj  = 1'b0;
    rr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      newpay(i);
    end
    drive();
    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tc_valid_in", tc_valid_in, 0);
    chk("rst_tc_vec_id", tc_vec_id, 0);
    chk("rst_tc_vec_a", tc_vec_a[7:0], 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_credit", credit_cnt, DEPTH);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // single request: req 1, tag 0x5A, ones times twos
    for (int e = 0; e < D; e++) begin
      pa[1][e] = 8'd1;
      pb[1][e] = 8'd2;
    end
    pt[1] = 8'h5A;
    v[1]  = 1'b1;
    rr    = 1'b1;
    step(0);
    chk("id_pack_0x15A", tc_vec_id, 20'h0015A);
    drain();
    chk("single_data", pop_data, 128);
    chk("single_req", pop_req, 1);
    chk("single_tag", pop_tag, 8'h5A);

    // signed result through req 2
    for (int e = 0; e < D; e++) begin
      pa[2][e] = 8'hFF;
      pb[2][e] = 8'h7F;
    end
    pt[2] = 8'hC3;
    v[2]  = 1'b1;
    step(0);
    drain();
    chk("signed_data", pop_data, -8128);
    chk("signed_req", pop_req, 2);

    // fairness with everyone held valid
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    rr   = 1'b1;
    base = dut_hs;
    repeat (12) step(1);
    chk("fair_issues", dut_hs - base, 12);
    drain();

    // random traffic
    repeat (300) begin
      for (int i = 0; i < N; i++)
        if (!v[i]) v[i] = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      step(2);
    end
    drain();

    // credit exhaustion, then a single-cycle pop
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    rr   = 1'b0;
    base = dut_hs;
    repeat (25) step(1);
    chk("cred_issues", dut_hs - base, DEPTH);
    chk("cred_zero", credit_cnt, 0);
    chk("cred_no_ready", req_ready, 0);
    rr = 1'b1;
    step(1);
    rr   = 1'b0;
    base = dut_hs;
    repeat (5) step(1);
    chk("pulse_issues", dut_hs - base, 1);
    drain();

    // spurious result while idle
    rr  = 1'b0;
    inj = 1'b1;
    step(0);
    inj = 1'b0;
    step(0);
    chk("spur_err", err, 1);
    repeat (5) begin
      step(0);
      chk("spur_err_sticky", err, 1);
    end

    // reset with requests in flight
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    repeat (5) step(1);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    drive();
    nrst = 1'b0;
    #1;
    chk("mid_req_ready", req_ready, 0);
    chk("mid_tc_valid_in", tc_valid_in, 0);
    chk("mid_tc_vec_id", tc_vec_id, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_credit", credit_cnt, DEPTH);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    rr = 1'b1;
    repeat (20) begin
      step(0);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
